// File: rtl/axi4_lite_pkg.sv
// Constants and helpers shared by the AXI4-Lite master and responder.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Number of address bits that select a byte within one data word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register storage: byte-strobed synchronous write port, combinational read, flat export.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_W-1:0]              wstrb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) regs_d[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  // Reads see the pre-write contents, so a read captured on a commit edge returns old data.
  assign rd_data = regs_q[rd_idx];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder terminating all five channels on a bank of software-visible registers.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = $clog2(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  logic                  rdy_en_q,  rdy_en_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q,  w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // rdy_en_q holds every ready low during reset and rises on the first edge after release.
  assign awready = rdy_en_q && !aw_held_q && !bvalid_q;
  assign wready  = rdy_en_q && !w_held_q  && !bvalid_q;
  assign arready = rdy_en_q && !rvalid_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid  && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = aw_held_q && w_held_q;
  assign wr_ok  = in_range(awaddr_q);
  assign rd_ok  = in_range(araddr);

  always_comb begin
    rdy_en_d  = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_data : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_en_q  <= rdy_en_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr_q[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  axi4_lite_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit && wr_ok),
    .idx     (awaddr_q[ADDR_LSB +: IDX_W]),
    .wdata   (wdata_q),
    .wstrb   (wstrb_q),
    .rd_idx  (araddr[ADDR_LSB +: IDX_W]),
    .rd_data (rd_data),
    .regs_out(regs_out)
  );

endmodule
